// File: rtl/agu_arbiter.sv
// Two-port arbiter sharing one address generator between fetch/branch (port 0) and load/store (port 1).
// Define AGU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default build gives port 0 fixed priority.
module agu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [6:0]  req0_opcode,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_pc,
  input  logic [31:0] req0_imm,
  input  logic [6:0]  req1_opcode,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_pc,
  input  logic [31:0] req1_imm,
  output logic [6:0]  agu_opcode,
  output logic [31:0] agu_rs1,
  output logic [31:0] agu_pc,
  output logic [31:0] agu_imm,
  input  logic [31:0] agu_address,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_address,
  output logic        res_id,
  output logic        res_error
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_address_q, res_address_d;
  logic        res_id_q, res_id_d;
  logic        res_error_q, res_error_d;

  logic        slot_free;
  logic        gnt_any;
  logic        gnt_id;
  logic [6:0]  sel_opcode;
  logic        supported;

`ifdef AGU_ARBITER_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    slot_free = !res_valid_q || res_ready;
    // reset is folded in so req_ready and the agu bus go idle while reset is held
    gnt_any   = slot_free && reset && (|req_valid);
`ifdef AGU_ARBITER_ROUND_ROBIN_EN
    gnt_id    = (&req_valid) ? ptr_q : req_valid[1];
    ptr_d     = gnt_any ? ~gnt_id : ptr_q;
`else
    gnt_id    = !req_valid[0];
`endif
  end

  always_comb begin
    req_ready  = 2'b00;
    agu_opcode = 7'b0000000;
    agu_rs1    = 32'h0;
    agu_pc     = 32'h0;
    agu_imm    = 32'h0;
    sel_opcode = gnt_id ? req1_opcode : req0_opcode;
    if (gnt_any) begin
      req_ready  = gnt_id ? 2'b10 : 2'b01;
      agu_opcode = sel_opcode;
      agu_rs1    = gnt_id ? req1_rs1 : req0_rs1;
      agu_pc     = gnt_id ? req1_pc  : req0_pc;
      agu_imm    = gnt_id ? req1_imm : req0_imm;
    end
  end

  always_comb begin
    case (sel_opcode)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC, OP_BRANCH: supported = 1'b1;
      default:                                                 supported = 1'b0;
    endcase
  end

  always_comb begin
    res_valid_d   = res_valid_q;
    res_address_d = res_address_q;
    res_id_d      = res_id_q;
    res_error_d   = res_error_q;
    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_id_d    = gnt_id;
      res_error_d = !supported;
      // unsupported opcodes never sample agu_address, so a floating bus cannot leak through
      if (!supported)
        res_address_d = 32'h0;
      else if (sel_opcode == OP_JALR)
        res_address_d = {agu_address[31:1], 1'b0};
      else
        res_address_d = agu_address;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid_q   <= 1'b0;
      res_address_q <= 32'h0;
      res_id_q      <= 1'b0;
      res_error_q   <= 1'b0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_address_q <= res_address_d;
      res_id_q      <= res_id_d;
      res_error_q   <= res_error_d;
    end
  end

`ifdef AGU_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign res_valid   = res_valid_q;
  assign res_address = res_address_q;
  assign res_id      = res_id_q;
  assign res_error   = res_error_q;

endmodule
